// File: rtl/rgb_palette_if.sv
// rgb_palette_if: lookup request/response handshake plus palette write port
// for rgb_palette_lut. IDX_W and CH_W must match the attached palette.
// With RGB_PALETTE_DIM_EN defined, a per-request dim bit is carried as well.
interface rgb_palette_if #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
);
  logic                  enable;
  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_W-1:0]      colour;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*CH_W-1:0]     rgb;
  logic                  out_err;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [3*CH_W-1:0]     wr_data;
`ifdef RGB_PALETTE_DIM_EN
  logic                  dim;
`endif

  // Requester / palette writer side
  modport master (
`ifdef RGB_PALETTE_DIM_EN
    output dim,
`endif
    output enable, in_valid, colour, out_ready, wr_en, wr_addr, wr_data,
    input  in_ready, out_valid, rgb, out_err
  );

  // Palette side
  modport slave (
`ifdef RGB_PALETTE_DIM_EN
    input  dim,
`endif
    input  enable, in_valid, colour, out_ready, wr_en, wr_addr, wr_data,
    output in_ready, out_valid, rgb, out_err
  );
endinterface

// File: rtl/rgb_palette_lut.sv
// rgb_palette_lut: writable colour palette, index -> packed {R,G,B}.
// Two-stage valid/ready pipeline (S1 = index, S2 = colour result) with
// backpressure; one lookup per cycle when not stalled.
// Optional macro RGB_PALETTE_DIM_EN adds a per-request dim bit that halves
// each channel of in-range results.
module rgb_palette_lut #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  rgb_palette_if.slave  bus
);
  localparam int RGB_W = 3 * CH_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH can equal 2**IDX_W, so the compare needs one extra bit.
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  logic [RGB_W-1:0] r_mem [DEPTH];

  logic             r_vld_p1;
  logic [IDX_W-1:0] r_idx_p1;
  logic             r_vld_p2;
  logic [RGB_W-1:0] r_rgb_p2;
  logic             r_err_p2;
`ifdef RGB_PALETTE_DIM_EN
  logic             r_dim_p1;
`endif

  logic             w_advance;
  logic             w_rd_in_range;
  logic             w_wr_in_range;
  logic [RGB_W-1:0] w_rd_data;
  logic [RGB_W-1:0] w_rgb_next;

  // Reset colour for an entry: bit2 = red, bit1 = green, bit0 = blue.
  function automatic logic [RGB_W-1:0] default_rgb(input logic [2:0] code);
    return {{CH_W{code[2]}}, {CH_W{code[1]}}, {CH_W{code[0]}}};
  endfunction

`ifdef RGB_PALETTE_DIM_EN
  // Halve every channel independently (no carry between channels).
  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] c);
    logic [RGB_W-1:0] d;
    d = '0;
    for (int k = 0; k < 3; k++) begin
      d[k*CH_W +: CH_W] = c[k*CH_W +: CH_W] >> 1;
    end
    return d;
  endfunction
`endif

  assign w_advance     = bus.enable && (!r_vld_p2 || bus.out_ready);
  assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_C);

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld_p2;
  assign bus.rgb       = r_rgb_p2;
  assign bus.out_err   = r_err_p2;

  // Table read of the S1 index; out-of-range indices resolve to black.
  always_comb begin
    w_rd_in_range = ({1'b0, r_idx_p1} < DEPTH_C);
    w_rd_data     = '0;
    if (w_rd_in_range) begin
      w_rd_data = r_mem[r_idx_p1[AW-1:0]];
    end
    w_rgb_next = w_rd_data;
`ifdef RGB_PALETTE_DIM_EN
    if (r_dim_p1) begin
      w_rgb_next = dim_rgb(w_rd_data);
    end
`endif
  end

  // Pipeline registers; everything holds unless the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_idx_p1 <= '0;
      r_vld_p2 <= 1'b0;
      r_rgb_p2 <= '0;
      r_err_p2 <= 1'b0;
`ifdef RGB_PALETTE_DIM_EN
      r_dim_p1 <= 1'b0;
`endif
    end else if (w_advance) begin
      // ---- input -> S1 ----
      r_vld_p1 <= bus.in_valid;
      r_idx_p1 <= bus.colour;
`ifdef RGB_PALETTE_DIM_EN
      r_dim_p1 <= bus.dim;
`endif
      // ---- S1 -> S2 (bubbles leave the last result on rgb) ----
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_rgb_p2 <= w_rgb_next;
        r_err_p2 <= !w_rd_in_range;
      end
    end
  end

  // Palette storage: defaults on reset, runtime writes while enabled.
  // A write landing on the same edge as the S1->S2 read is not seen by
  // that read, since the read samples the pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= default_rgb(i[2:0]);
      end
    end else if (bus.enable && bus.wr_en && w_wr_in_range) begin
      r_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_rgb_palette_lut.sv
// tb_rgb_palette_lut: directed checks of rgb_palette_lut with DEPTH=8 and
// DEPTH=6 instances (plus a CH_W=4 instance when RGB_PALETTE_DIM_EN is set).
module tb_rgb_palette_lut;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rgb_palette_if #(.IDX_W(3), .CH_W(8)) if8 ();
  rgb_palette_if #(.IDX_W(3), .CH_W(8)) if6 ();

  rgb_palette_lut #(.DEPTH(8), .IDX_W(3), .CH_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8)
  );
  rgb_palette_lut #(.DEPTH(6), .IDX_W(3), .CH_W(8)) dut6 (
    .clk(clk), .rst(rst), .bus(if6)
  );

`ifdef RGB_PALETTE_DIM_EN
  rgb_palette_if #(.IDX_W(3), .CH_W(4)) if4 ();
  rgb_palette_lut #(.DEPTH(8), .IDX_W(3), .CH_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );
`endif

  typedef struct {
    logic [2:0]  colour;
    logic [23:0] rgb;
    logic        err;
  } vec_t;
  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic lookup8(input logic [2:0] c);
    if8.in_valid = 1'b1;
    if8.colour   = c;
    step();
    if8.in_valid = 1'b0;
    step();
  endtask

  task automatic lookup6(input logic [2:0] c);
    if6.in_valid = 1'b1;
    if6.colour   = c;
    step();
    if6.in_valid = 1'b0;
    step();
  endtask

  task automatic write8(input logic [2:0] a, input logic [23:0] d);
    if8.wr_en   = 1'b1;
    if8.wr_addr = a;
    if8.wr_data = d;
    step();
    if8.wr_en   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 24'h000000, 1'b0};
    vecs[1] = '{3'd1, 24'h0000FF, 1'b0};
    vecs[2] = '{3'd2, 24'h00FF00, 1'b0};
    vecs[3] = '{3'd3, 24'h00FFFF, 1'b0};
    vecs[4] = '{3'd4, 24'hFF0000, 1'b0};
    vecs[5] = '{3'd5, 24'hFF00FF, 1'b0};
    vecs[6] = '{3'd6, 24'hFFFF00, 1'b0};
    vecs[7] = '{3'd7, 24'hFFFFFF, 1'b0};

    if8.enable = 1'b1; if8.in_valid = 1'b0; if8.colour = '0; if8.out_ready = 1'b1;
    if8.wr_en = 1'b0; if8.wr_addr = '0; if8.wr_data = '0;
    if6.enable = 1'b1; if6.in_valid = 1'b0; if6.colour = '0; if6.out_ready = 1'b1;
    if6.wr_en = 1'b0; if6.wr_addr = '0; if6.wr_data = '0;
`ifdef RGB_PALETTE_DIM_EN
    if8.dim = 1'b0;
    if6.dim = 1'b0;
    if4.enable = 1'b1; if4.in_valid = 1'b0; if4.colour = '0; if4.out_ready = 1'b1;
    if4.wr_en = 1'b0; if4.wr_addr = '0; if4.wr_data = '0; if4.dim = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_rgb",       32'(if8.rgb),       32'd0);
    chk("rst_out_err",   32'(if8.out_err),   32'd0);
    chk("rst6_out_valid", 32'(if6.out_valid), 32'd0);
    rst = 1'b0;
    step();

    // Default palette, back-to-back stream 0..7
    for (int s = 0; s < 9; s++) begin
      if8.in_valid = (s < 8);
      if8.colour   = (s < 8) ? vecs[s].colour : 3'd0;
      #1;
      chk("stream_in_ready", 32'(if8.in_ready), 32'd1);
      step();
      if (s == 0) begin
        chk("stream_lat_valid", 32'(if8.out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(if8.out_valid), 32'd1);
        chk("stream_rgb",   32'(if8.rgb),       32'(vecs[s-1].rgb));
        chk("stream_err",   32'(if8.out_err),   32'(vecs[s-1].err));
      end
    end
    step();
    chk("bubble_valid", 32'(if8.out_valid), 32'd0);
    chk("bubble_rgb_hold", 32'(if8.rgb), 32'hFFFFFF);

    // Write then read
    write8(3'd3, 24'h123456);
    lookup8(3'd3);
    chk("wr_read_valid", 32'(if8.out_valid), 32'd1);
    chk("wr_read_rgb",   32'(if8.rgb),       32'h123456);

    // Collision: write lands on the edge the lookup moves into S2
    if8.in_valid = 1'b1; if8.colour = 3'd3;
    step();
    if8.in_valid = 1'b0;
    write8(3'd3, 24'hABCDEF);
    chk("collide_old_rgb", 32'(if8.rgb), 32'h123456);
    lookup8(3'd3);
    chk("collide_new_rgb", 32'(if8.rgb), 32'hABCDEF);

    // Backpressure: 4, 2, 1 with out_ready low for 3 cycles
    if8.in_valid = 1'b1; if8.colour = 3'd4;
    step();
    if8.colour = 3'd2;
    step();
    chk("bp_first_rgb", 32'(if8.rgb), 32'hFF0000);
    if8.out_ready = 1'b0;
    if8.colour    = 3'd1;
    #1;
    chk("bp_in_ready_low", 32'(if8.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", 32'(if8.out_valid), 32'd1);
      chk("bp_hold_rgb",   32'(if8.rgb),       32'hFF0000);
      chk("bp_hold_ready", 32'(if8.in_ready),  32'd0);
    end
    if8.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(if8.in_ready), 32'd1);
    step();
    if8.in_valid = 1'b0;
    chk("bp_second_rgb", 32'(if8.rgb), 32'h00FF00);
    step();
    chk("bp_third_rgb", 32'(if8.rgb), 32'h0000FF);
    chk("bp_third_valid", 32'(if8.out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(if8.out_valid), 32'd0);

    // Enable low freezes the pipe and blocks writes
    if8.in_valid = 1'b1; if8.colour = 3'd5;
    step();
    if8.colour = 3'd6;
    step();
    chk("en_pre_rgb", 32'(if8.rgb), 32'hFF00FF);
    if8.enable = 1'b0; if8.colour = 3'd7;
    if8.wr_en = 1'b1; if8.wr_addr = 3'd5; if8.wr_data = 24'h111111;
    #1;
    chk("en_in_ready", 32'(if8.in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("en_frozen_valid", 32'(if8.out_valid), 32'd1);
      chk("en_frozen_rgb",   32'(if8.rgb),       32'hFF00FF);
    end
    if8.enable = 1'b1; if8.wr_en = 1'b0;
    step();
    if8.in_valid = 1'b0;
    chk("en_resume_rgb6", 32'(if8.rgb), 32'hFFFF00);
    step();
    chk("en_resume_rgb7", 32'(if8.rgb), 32'hFFFFFF);
    lookup8(3'd5);
    chk("en_write_blocked", 32'(if8.rgb), 32'hFF00FF);

    // Asynchronous reset between edges
    write8(3'd3, 24'h010203);
    lookup8(3'd3);
    chk("prerst_rgb", 32'(if8.rgb), 32'h010203);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(if8.out_valid), 32'd0);
    chk("async_rst_rgb",   32'(if8.rgb),       32'd0);
    #1 rst = 1'b0;
    step();
    lookup8(3'd3);
    chk("rst_restores_3", 32'(if8.rgb), 32'h00FFFF);

    // DEPTH=6 range handling
    lookup6(3'd7);
    chk("range7_valid", 32'(if6.out_valid), 32'd1);
    chk("range7_rgb",   32'(if6.rgb),       32'd0);
    chk("range7_err",   32'(if6.out_err),   32'd1);
    lookup6(3'd5);
    chk("range5_rgb", 32'(if6.rgb),     32'hFF00FF);
    chk("range5_err", 32'(if6.out_err), 32'd0);
    if6.wr_en = 1'b1; if6.wr_addr = 3'd6; if6.wr_data = 24'hAAAAAA;
    step();
    if6.wr_addr = 3'd5; if6.wr_data = 24'h0A0B0C;
    step();
    if6.wr_en = 1'b0;
    lookup6(3'd6);
    chk("range6_rgb", 32'(if6.rgb),     32'd0);
    chk("range6_err", 32'(if6.out_err), 32'd1);
    lookup6(3'd5);
    chk("range5_wr_rgb", 32'(if6.rgb),  32'h0A0B0C);
    chk("range5_wr_err", 32'(if6.out_err), 32'd0);

`ifdef RGB_PALETTE_DIM_EN
    // Dimming on a 4-bit-per-channel palette
    if4.dim = 1'b1; if4.in_valid = 1'b1; if4.colour = 3'd7;
    step();
    if4.in_valid = 1'b0;
    step();
    chk("dim7_on", 32'(if4.rgb), 32'h777);
    if4.dim = 1'b0; if4.in_valid = 1'b1; if4.colour = 3'd7;
    step();
    if4.in_valid = 1'b0;
    step();
    chk("dim7_off", 32'(if4.rgb), 32'hFFF);
    if4.dim = 1'b1; if4.in_valid = 1'b1; if4.colour = 3'd4;
    step();
    if4.in_valid = 1'b0;
    step();
    chk("dim4_on", 32'(if4.rgb), 32'h700);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgb_palette_lut.md
Name: rgb_palette_lut

Overview:
- Parametrised, writable colour palette that maps a colour index to a packed {R,G,B} code.
- Successor to the fixed 8-entry read-only converter. Adds configurable depth and channel width, a runtime write port, and a 2-stage valid/ready pipeline with backpressure.
- Sits between colour-index sources (e.g. pattern/traffic logic) and display or LED drivers.

Parameters:
- DEPTH, 8: number of palette entries, 1..256.
- IDX_W, 3: index width; must satisfy 2**IDX_W >= DEPTH.
- CH_W, 8: bits per colour channel, 1..16; rgb width is 3*CH_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global enable; low freezes pipeline and blocks writes.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted when in_valid && in_ready.
- colour  in  IDX_W  lookup index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result when out_valid && out_ready.
- rgb  out  3*CH_W  result, {R[3*CH_W-1:2*CH_W], G, B[CH_W-1:0]}.
- out_err  out  1  result came from an index >= DEPTH.
- wr_en  in  1  palette write strobe.
- wr_addr  in  IDX_W  write index.
- wr_data  in  3*CH_W  write value, same packing as rgb.

Behaviour:
- Reset (async assert; deassert takes effect on next clk edge):
  - out_valid=0, rgb=0, out_err=0, both stage valid bits cleared.
  - Every entry i loads default colour (i mod 8), with M = all-ones of CH_W:
    - 0 black {0,0,0}
    - 1 blue {0,0,M}
    - 2 green {0,M,0}
    - 3 cyan {0,M,M}
    - 4 red {M,0,0}
    - 5 magenta {M,0,M}
    - 6 yellow {M,M,0}
    - 7 white {M,M,M}
- Pipeline, two stages:
  - S1 holds index and valid.
  - S2 holds rgb, out_err and out_valid.
- advance = enable && (!out_valid || out_ready); in_ready = advance (combinational).
- On advance:
  - S1 <= {in_valid, colour}.
  - S2 <= table read of S1 index, valid = S1 valid.
- Latency: accepted request appears on rgb/out_valid exactly 2 cycles later if no stall. Full throughput is 1 lookup per cycle.
- Stall (out_valid && !out_ready, or enable=0):
  - S1 and S2 hold.
  - rgb and out_err stable while out_valid=1.
  - in_ready=0.
- Bubbles:
  - S1 valid=0 propagates as out_valid=0.
  - rgb holds its previous value when out_valid=0.
- Out-of-range index (>= DEPTH): rgb=0, out_err=1. Still consumes one slot and completes the handshake.
- Writes:
  - When enable && wr_en && wr_addr < DEPTH, entry updated at clk edge.
  - wr_addr >= DEPTH is ignored.
  - wr_en with enable=0 is ignored.
- Read/write collision: the table is read on the edge S1 moves into S2.
  - A write on that same edge to the same entry is not visible (old data returned).
  - A write on any earlier edge is visible.
  - Writes proceed during output stall.
- Reset mid-operation: in-flight lookups are discarded and palette writes are lost (defaults restored).

Optional Feature:
- Macro RGB_PALETTE_DIM_EN.
- Defined:
  - Adds input port dim (1 bit), sampled with the request into S1.
  - When set, each channel of the S2 result is shifted right by 1 (e.g. 0xFF -> 0x7F).
  - out_err results stay 0.
- Undefined: no dim port; results unmodified.

Test Plan:
- Defaults (DEPTH=8, CH_W=8):
  - Release rst; stream colour 0..7 back-to-back with out_ready=1.
  - Expect out_valid on cycles 2..9 and rgb 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF.
- Write then read:
  - wr_en, wr_addr=3, wr_data=123456; next cycle look up 3 -> rgb=123456 after 2 cycles.
  - Collision case: write 3=ABCDEF on the edge the index-3 lookup enters S2 -> that result is 123456; a following lookup returns ABCDEF.
- Backpressure:
  - Stream 4, 2, 1 with out_ready low for 3 cycles after first out_valid.
  - Expect rgb=FF0000 held, in_ready=0 while stalled; then 00FF00 and 0000FF in order, none lost or duplicated.
- Range (DEPTH=6, IDX_W=3):
  - Look up 7 -> rgb=0, out_err=1.
  - Write to address 6 -> ignored; lookup 6 still returns 0 with out_err=1.
- Enable/reset:
  - enable=0 mid-stream freezes outputs and blocks wr_en.
  - Asserting rst between clock edges clears out_valid immediately and restores entry 3 to 00FFFF.
- With RGB_PALETTE_DIM_EN, CH_W=4: lookup 7 with dim=1 -> rgb=777; dim=0 -> FFF.
